// File: rtl/uart_rx_mv_pkg.sv
// Shared types for the oversampling UART receiver: runtime frame config,
// per-word error flags and receiver FSM states.
package uart_rx_mv_pkg;

  localparam int unsigned UART_DATA_MAX = 9;

  typedef struct packed {
    logic       parity_en;
    logic       parity_even;
    logic [3:0] data_len;
    logic [1:0] stop_len;
  } uart_config;

  typedef struct packed {
    logic brk;
    logic frm;
    logic par;
  } uart_rx_err_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRKWAIT
  } uart_rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head read.
// A push while full is accepted only when a pop frees a slot in the same clock.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_level = r_cnt;
  assign o_rdata = r_mem[r_rptr];
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_mv.sv
// Oversampling UART receiver: synchroniser, 3-sample majority vote, frame FSM
// with parity/framing/break detection, buffered through a receive FIFO.
module uart_rx_mv
  import uart_rx_mv_pkg::*;
#(
  parameter int unsigned OSM         = 16,
  parameter int unsigned DATA_MAX    = UART_DATA_MAX,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          pls_rx,
  input  logic                          uart_rxd,
  input  uart_config                    ucfg,
  output logic [DATA_MAX-1:0]           rx_data,
  output uart_rx_err_t                  rx_err,
  output logic                          valid_rx,
  input  logic                          ready_rx,
  output logic                          overrun,
  input  logic                          clr_ovr,
  output logic                          busy_rx,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned TW = $clog2(OSM);
  localparam int unsigned BW = $clog2(DATA_MAX);
  localparam int unsigned FW = DATA_MAX + 3;

  uart_rx_state_e         r_state, w_state_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [TW-1:0]          r_tick;
  logic [BW-1:0]          r_bitcnt;
  logic [DATA_MAX-1:0]    r_data;
  logic                   r_s0, r_s1;
  logic                   r_par_bit, r_frm, r_stop0;
  uart_config             r_cfg;
  logic                   r_ovr;

  logic         w_rxd, w_vote, w_vote_tick, w_bit_end, w_start_det;
  logic         w_last_data, w_last_stop, w_stop0, w_push, w_pop;
  logic         w_full, w_empty;
  uart_rx_err_t w_err, w_head_err;
  logic [DATA_MAX-1:0] w_head_data;

  assign w_rxd       = r_sync[SYNC_STAGES-1];
  assign w_start_det = pls_rx & (r_state == IDLE) & r_prev & ~w_rxd;
  assign w_vote_tick = pls_rx & (r_state != IDLE) & (r_tick == TW'(OSM/2 + 1));
  assign w_bit_end   = pls_rx & (r_tick == TW'(OSM - 1));
  assign w_vote      = (r_s0 & r_s1) | (r_s0 & w_rxd) | (r_s1 & w_rxd);
  assign w_last_data = (32'(r_bitcnt) + 1 == 32'(r_cfg.data_len));
  assign w_last_stop = (32'(r_bitcnt) + 1 >= 32'(r_cfg.stop_len));

  // With a single stop bit the first stop value is the vote being pushed now.
  assign w_stop0   = (r_bitcnt == '0) ? w_vote : r_stop0;
  assign w_err.par = r_cfg.parity_en & (((^r_data) ^ r_par_bit) != ~r_cfg.parity_even);
  assign w_err.frm = r_frm | ~w_vote;
  assign w_err.brk = (r_data == '0) & ~(r_cfg.parity_en & r_par_bit) & ~w_stop0;

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    case (r_state)
      IDLE:    if (w_start_det) w_state_next = START;
      START: begin
        if (w_vote_tick && w_vote) w_state_next = IDLE;
        else if (w_bit_end)        w_state_next = DATA;
      end
      DATA:    if (w_bit_end && w_last_data)
                 w_state_next = r_cfg.parity_en ? PARITY : STOP;
      PARITY:  if (w_bit_end) w_state_next = STOP;
      STOP: begin
        if (w_vote_tick && w_last_stop) begin
          w_push       = 1'b1;
          w_state_next = w_err.brk ? BRKWAIT : IDLE;
        end
      end
      BRKWAIT: if (pls_rx && w_rxd) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync    <= '1;
      r_prev    <= 1'b1;
      r_tick    <= '0;
      r_bitcnt  <= '0;
      r_data    <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_par_bit <= 1'b0;
      r_frm     <= 1'b0;
      r_stop0   <= 1'b1;
      r_cfg     <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rxd};
      if (pls_rx) r_prev <= w_rxd;
      if (w_start_det) begin
        r_cfg     <= ucfg;
        r_tick    <= '0;
        r_bitcnt  <= '0;
        r_data    <= '0;
        r_par_bit <= 1'b0;
        r_frm     <= 1'b0;
        r_stop0   <= 1'b1;
      end else if (pls_rx && r_state != IDLE && r_state != BRKWAIT) begin
        r_tick <= (r_tick == TW'(OSM - 1)) ? '0 : r_tick + 1'b1;
        if (r_tick == TW'(OSM/2 - 1)) r_s0 <= w_rxd;
        if (r_tick == TW'(OSM/2))     r_s1 <= w_rxd;
        if (w_vote_tick) begin
          case (r_state)
            DATA:    r_data[r_bitcnt] <= w_vote;
            PARITY:  r_par_bit <= w_vote;
            STOP: begin
              r_frm <= r_frm | ~w_vote;
              if (r_bitcnt == '0) r_stop0 <= w_vote;
            end
            default: ;
          endcase
        end
        if (w_bit_end)
          r_bitcnt <= (w_state_next != r_state) ? '0 : r_bitcnt + 1'b1;
      end
    end
  end

  assign w_pop = valid_rx & ready_rx;

  uart_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_wdata ({w_err, r_data}),
    .i_pop   (w_pop),
    .o_rdata ({w_head_err, w_head_data}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        r_ovr <= 1'b0;
    else if (w_push && w_full && !w_pop) r_ovr <= 1'b1;
    else if (clr_ovr)                 r_ovr <= 1'b0;
  end

  assign valid_rx = ~w_empty;
  assign rx_data  = w_empty ? '0 : w_head_data;
  assign rx_err   = w_empty ? '0 : w_head_err;
  assign overrun  = r_ovr;
  assign busy_rx  = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_mv.sv
// Randomised self-checking bench for uart_rx_mv: a serial line driver builds
// frames bit by bit and expected words are derived from the frame rules.
module tb_uart_rx_mv;
  import uart_rx_mv_pkg::*;

  localparam int OSM   = 16;
  localparam int DMAX  = 9;
  localparam int DEPTH = 8;
  localparam int SYNC  = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic pls_rx = 1'b1;
  logic uart_rxd = 1'b1;
  logic ready_rx = 1'b0;
  logic clr_ovr = 1'b0;
  uart_config ucfg;
  logic [DMAX-1:0] rx_data;
  uart_rx_err_t rx_err;
  logic valid_rx, overrun, busy_rx;
  logic [$clog2(DEPTH):0] level;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int t0_cyc = 0;
  logic v_q = 1'b0;

  uart_rx_mv #(.OSM(OSM), .DATA_MAX(DMAX), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rstn(rstn), .pls_rx(pls_rx), .uart_rxd(uart_rxd), .ucfg(ucfg),
    .rx_data(rx_data), .rx_err(rx_err), .valid_rx(valid_rx), .ready_rx(ready_rx),
    .overrun(overrun), .clr_ovr(clr_ovr), .busy_rx(busy_rx), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid_rx && !v_q) rise_cyc = cyc;
    v_q = valid_rx;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic uart_config mkcfg(input bit pen, input bit peven, input int len, input int stops);
    uart_config c;
    c.parity_en = pen; c.parity_even = peven;
    c.data_len = 4'(len); c.stop_len = 2'(stops);
    return c;
  endfunction

  function automatic logic [8:0] dmask(input uart_config c);
    logic [8:0] one = 9'h1;
    return (one << c.data_len) - 9'h1;
  endfunction

  // Line driver: start, data LSB first, optional parity, stop bits; OSM clocks per bit.
  task automatic send_frame(input logic [8:0] d, input uart_config c, input bit bad_par,
                            input int glitch_idx, input int max_bits);
    logic bits [16];
    int n = 0;
    logic [8:0] dm = d & dmask(c);
    bits[n++] = 1'b0;
    for (int i = 0; i < int'(c.data_len); i++) bits[n++] = dm[i];
    if (c.parity_en) bits[n++] = (c.parity_even ? ^dm : ~^dm) ^ bad_par;
    for (int i = 0; i < int'(c.stop_len); i++) bits[n++] = 1'b1;
    if (max_bits < n) n = max_bits;
    ucfg = c;
    for (int b = 0; b < n; b++) begin
      uart_rxd = bits[b];
      if (b == 0) t0_cyc = cyc;
      for (int t = 0; t < OSM; t++) begin
        if (b == glitch_idx && t == OSM/2 + 2) uart_rxd = ~bits[b];
        else uart_rxd = bits[b];
        step();
        if (b == 0 && t == 4) ucfg = uart_config'(8'($urandom));
      end
    end
    uart_rxd = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [8:0] exp_d, input logic [2:0] exp_e);
    int k = 0;
    while (!valid_rx && k < 40 * OSM) begin step(); k++; end
    check({tag, "_valid"}, 32'(valid_rx), 32'd1);
    check({tag, "_data"}, 32'(rx_data), 32'(exp_d));
    check({tag, "_err"}, 32'(rx_err), 32'(exp_e));
    ready_rx = 1'b1;
    step();
    ready_rx = 1'b0;
  endtask

  initial begin
    uart_config c;
    logic [8:0] d;
    bit bad;
    int nb, dt;
    ucfg = mkcfg(0, 0, 8, 1);
    step(3);
    check("rst_valid", 32'(valid_rx), 0);
    check("rst_level", 32'(level), 0);
    check("rst_busy", 32'(busy_rx), 0);
    check("rst_ovr", 32'(overrun), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_err", 32'(rx_err), 0);
    rstn = 1'b1;
    step(4);

    // 8E2 0x0F with latency window around the last stop bit centre
    c = mkcfg(1, 1, 8, 2);
    rise_cyc = -1;
    send_frame(9'h0F, c, 0, -1, 99);
    nb = 1 + 8 + 1 + 2;
    dt = rise_cyc - t0_cyc;
    check("lat_8e2", 32'(dt >= (nb - 1) * OSM + OSM/2 && dt <= (nb - 1) * OSM + OSM/2 + SYNC + 4), 1);
    pop_check("f8e2", 9'h0F, 3'b000);

    send_frame(9'h0F, mkcfg(1, 1, 8, 1), 1, -1, 99);
    pop_check("par_err", 9'h0F, 3'b001);
    send_frame(9'h55, mkcfg(1, 0, 7, 1), 0, -1, 99);
    pop_check("f7o1", 9'h55, 3'b000);

    // one-tick low glitch on the idle line
    uart_rxd = 1'b0; step(); uart_rxd = 1'b1;
    step(SYNC + 2 + OSM);
    check("glitch_busy", 32'(busy_rx), 0);
    check("glitch_level", 32'(level), 0);

    send_frame(9'hA5, mkcfg(0, 0, 8, 1), 0, 4, 99);
    pop_check("vote_a5", 9'hA5, 3'b000);

    for (int i = 0; i < 12; i++) begin
      c = mkcfg(1'($urandom), 1'($urandom), 5 + int'($urandom % 5), 1 + int'($urandom % 2));
      d = 9'($urandom) & dmask(c);
      bad = ($urandom % 4 == 0);
      send_frame(d, c, bad, -1, 99);
      pop_check("rand", d, {2'b00, bad & c.parity_en});
      step(int'($urandom % 8));
    end

    // break: line low for 40 bit-times
    ucfg = mkcfg(0, 0, 8, 1);
    step(2);
    uart_rxd = 1'b0;
    step(40 * OSM);
    check("brk_level", 32'(level), 1);
    pop_check("brk", 9'h000, 3'b110);
    step(4 * OSM);
    check("brk_nopush", 32'(level), 0);
    check("brk_wait_busy", 32'(busy_rx), 1);
    uart_rxd = 1'b1;
    step(2 * OSM);
    check("brk_exit_busy", 32'(busy_rx), 0);
    send_frame(9'h5A, mkcfg(0, 0, 8, 1), 0, -1, 99);
    pop_check("post_brk", 9'h5A, 3'b000);

    // overflow: nine frames into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) send_frame(9'(i), mkcfg(0, 0, 8, 1), 0, -1, 99);
    step(OSM);
    check("ovf_level", 32'(level), DEPTH);
    check("ovf_flag", 32'(overrun), 1);
    for (int i = 1; i <= DEPTH; i++) pop_check("ovf_pop", 9'(i), 3'b000);
    check("ovf_empty", 32'(valid_rx), 0);
    check("ovf_sticky", 32'(overrun), 1);
    clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
    check("ovf_clr", 32'(overrun), 0);

    // reset while receiving the data bits of 0x3C
    send_frame(9'h3C, mkcfg(0, 0, 8, 1), 0, -1, 5);
    check("mid_busy", 32'(busy_rx), 1);
    rstn = 1'b0;
    step(2);
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_busy", 32'(busy_rx), 0);
    rstn = 1'b1;
    step(OSM);
    check("mid_rst_nopush", 32'(level), 0);
    send_frame(9'hC3, mkcfg(0, 0, 8, 1), 0, -1, 99);
    pop_check("post_rst", 9'hC3, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
